servo_ramp_ctrl: RTL
====================

# servo_ramp_ctrl

Multi-channel motion controller for the SG90 servo PWM generators. Accepts target-angle commands through a valid/ready interface and walks each channel's angle toward its target by a bounded step once per 20 ms servo frame. The registered per-channel angle buses drive the `Angel` inputs of the per-channel PWM instances, which limits slew rate and current draw.

## Interface
Parameters:
- `NUM_CH`, 4: number of servo channels; the `cmd_ch` width is 2 for the default.
- `CLK_HZ`, 100_000_000: `iclk` frequency.
- `FRAME_US`, 20000: ramp update period in µs.
- `INIT_ANGLE`, 90: reset angle and reset target for every channel.
- `DEF_STEP`, 2: reset step size in degrees per frame.

Ports:
- `iclk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command can be accepted.
- `cmd_ch`, in, 2: target channel index.
- `cmd_angle`, in, 8: target angle in degrees; values above 180 are clamped to 180.
- `cmd_step`, in, 4: degrees per frame; 0 means jump at the next frame.
- `frame_tick`, out, 1: one-cycle pulse on the last cycle of each frame.
- `angle_out`, out, 8*NUM_CH: current angle per channel; channel k is at [8k+7:8k].
- `busy`, out, NUM_CH: the channel's current angle differs from its target.
- `done`, out, NUM_CH: one-cycle pulse when a channel reaches its target.

## Operation
- Frame counter:
  - `FRAME_CNT` = CLK_HZ/1_000_000*FRAME_US. The counter is 32 bits.
  - The counter runs 0..FRAME_CNT-1 and wraps to 0.
  - `frame_tick` = (cnt == FRAME_CNT-1), decoded combinationally from the registered count.
- Command handshake:
  - `cmd_ready` = ~`frame_tick`, so commands are never accepted in an update cycle.
  - A transfer occurs when `cmd_valid` and `cmd_ready` are both high.
  - On a transfer, channel `cmd_ch` loads tgt = min(`cmd_angle`, 180) and step = `cmd_step`.
  - `cur` is not touched by a transfer.
  - A new command overwrites an in-progress target. The ramp continues from the present `cur`, with no done pulse for the abandoned target.
  - `cmd_ch` ≥ NUM_CH: the command is accepted and discarded.
- Ramp, applied to each channel independently when `frame_tick` is high:
  - The difference cur−tgt is computed as a 9-bit signed value.
  - cur<tgt: cur += min(step, tgt−cur).
  - cur>tgt: cur −= min(step, cur−tgt).
  - step==0: cur = tgt.
  - cur==tgt: no change.
- `busy[k]` = (cur_k != tgt_k), combinational from the registers.
  - It rises in the cycle after a transfer that sets a different target.
- `done[k]`:
  - Registered. It is high for exactly one cycle when a tick update makes cur_k equal to tgt_k while it was previously unequal.
  - A command whose target equals `cur` produces no `done` and no `busy`.
- Reset, asynchronous, may occur mid-ramp:
  - cnt=0, cur=tgt=INIT_ANGLE, step=DEF_STEP.
  - `done`=0, `busy`=0, `frame_tick`=0, `cmd_ready`=1, `angle_out`=INIT_ANGLE on every channel.
  - Any pending ramp is discarded.

## Timing
- `angle_out` is registered and changes only at the clock edge that ends a `frame_tick` cycle. The new value is visible in the cycle after the tick and stays stable for FRAME_CNT cycles.
- Command latency:
  - A transfer in cycle t updates tgt at the edge ending cycle t.
  - The first angle movement happens at the next tick edge. That is at most FRAME_CNT−1 cycles later if the transfer immediately follows a tick.
- The first `frame_tick` after reset release occurs in cycle FRAME_CNT−1, counting from cycle 0 as the first clocked cycle.
- `done` rises in the same cycle that `angle_out` shows the final value.
- Ramp duration from a to b with step s>0: ceil(|a−b|/s) ticks.
- The PWM block samples its angle input at its own frame boundary, which is unaligned. Holding `angle_out` for a full frame keeps this skew to at most one frame of extra delay.

## Structure
- Package `servo_pkg` holds:
  - `MAX_ANGLE`=180 and `US_PER_S`=1_000_000.
  - The angle type (8-bit), the step type (4-bit), and the function `frame_cnt(clk_hz, frame_us)`.
- Sub-module `servo_ramp_chan`, one instance per channel via generate:
  - Contains the tgt/step/cur registers, the clamp, the ramp arithmetic and the `done` flag.
  - Inputs: `load`, `cmd_angle`, `cmd_step`, `tick`.
- Top level holds the frame counter, the `cmd_ch` decode and `cmd_ready`.

## Test plan
Bench parameters: CLK_HZ=1_000_000, FRAME_US=10, giving FRAME_CNT=10.
- Reset values: hold reset, release it, and run 30 cycles.
  - During reset every `angle_out` is 90, `busy`=0 and `cmd_ready`=1.
  - `frame_tick` fires at cycles 9, 19 and 29.
- Ramp up: send ch0, angle 100, step 3 just after a tick.
  - `angle_out[0]` after successive ticks: 93, 96, 99, 100.
  - `done[0]` pulses once with the value 100; `busy[0]` falls in the same cycle.
- Clamp and jump: send ch2, angle 250, step 0.
  - At the next tick `angle_out[2]`=180; `done[2]` pulses once.
- Handshake collision: hold `cmd_valid` high across a tick.
  - `cmd_ready`=0 in the tick cycle and no load occurs.
  - The transfer completes in the following cycle.
- Retarget mid-ramp: ch1 runs 90→150 at step 5.
  - After 2 ticks (angle 100), send target 95 at step 5.
  - The next tick gives 95 with a single `done`; no `done` is issued for 150.
- Reset mid-ramp: assert `reset_n`=0 asynchronously mid-frame while ch3 is ramping.
  - Outputs return to 90 within the reset cycle; `busy`=0.
  - No `done` is issued after release.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo ramp controller.
//   MAX_ANGLE : upper clamp for commanded angles (degrees)
//   US_PER_S  : microseconds per second, used to size the frame counter
//   angle_t   : 8-bit angle in degrees
//   step_t    : 4-bit ramp step in degrees per frame
//   frame_cnt : clock cycles per ramp frame
package servo_pkg;

    localparam int unsigned MAX_ANGLE = 180;
    localparam int unsigned US_PER_S  = 1_000_000;

    typedef logic [7:0] angle_t;
    typedef logic [3:0] step_t;

    function automatic logic [31:0] frame_cnt(input int unsigned clk_hz,
                                              input int unsigned frame_us);
        return 32'(clk_hz / US_PER_S * frame_us);
    endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Command channel of the servo ramp controller (valid/ready).
//   cmd_valid : command present (master -> slave)
//   cmd_ready : command can be accepted (slave -> master)
//   cmd_ch    : target channel index
//   cmd_angle : target angle in degrees, clamped to 180 by the slave
//   cmd_step  : degrees per frame, 0 jumps at the next frame
interface servo_ramp_ctrl_if #(
    parameter int unsigned CH_W = 2
);
    import servo_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    angle_t          cmd_angle;
    step_t           cmd_step;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_angle,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_angle,
        input  cmd_step,
        output cmd_ready
    );

endinterface

// File: rtl/servo_ramp_chan.sv
// One servo channel: holds target, step and current angle and walks the
// current angle toward the target once per frame tick.
//   iclk, reset_n : clock, asynchronous active-low reset
//   load          : capture cmd_angle (clamped) and cmd_step as new target
//   cmd_angle     : requested angle
//   cmd_step      : requested step size
//   tick          : frame update strobe
//   angle         : registered current angle
//   busy          : current angle differs from target
//   done          : one-cycle pulse when a tick brings current onto target
module servo_ramp_chan
    import servo_pkg::*;
#(
    parameter int unsigned INIT_ANGLE = 90,
    parameter int unsigned DEF_STEP   = 2
) (
    input  logic   iclk,
    input  logic   reset_n,
    input  logic   load,
    input  angle_t cmd_angle,
    input  step_t  cmd_step,
    input  logic   tick,
    output angle_t angle,
    output logic   busy,
    output logic   done
);

    angle_t            cur_q, cur_d;
    angle_t            tgt_q, tgt_d;
    step_t             step_q, step_d;
    logic              done_q, done_d;
    logic signed [8:0] diff;
    angle_t            mag;
    angle_t            delta;

    always_comb begin
        tgt_d  = tgt_q;
        step_d = step_q;
        if (load) begin
            tgt_d  = (cmd_angle > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : cmd_angle;
            step_d = cmd_step;
        end

        diff  = $signed({1'b0, cur_q}) - $signed({1'b0, tgt_q});
        mag   = diff[8] ? 8'(-diff) : diff[7:0];
        // Never overshoot: clip the step to the remaining distance.
        delta = ({4'b0, step_q} < mag) ? {4'b0, step_q} : mag;

        cur_d  = cur_q;
        done_d = 1'b0;
        if (tick && (diff != 9'sd0)) begin
            if (step_q == '0) begin
                cur_d = tgt_q;
            end else if (diff[8]) begin
                cur_d = cur_q + delta;
            end else begin
                cur_d = cur_q - delta;
            end
            done_d = (cur_d == tgt_q);
        end
    end

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q  <= angle_t'(INIT_ANGLE);
            tgt_q  <= angle_t'(INIT_ANGLE);
            step_q <= step_t'(DEF_STEP);
            done_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end

    assign angle = cur_q;
    assign busy  = (cur_q != tgt_q);
    assign done  = done_q;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo ramp controller. Accepts target-angle commands and
// steps each channel toward its target once per servo frame.
//   iclk, reset_n : clock, asynchronous active-low reset
//   cmd           : command channel (slave side)
//   frame_tick    : one-cycle pulse on the last cycle of each frame
//   angle_out     : current angle per channel, channel k at [8k+7:8k]
//   busy          : per-channel current != target
//   done          : per-channel one-cycle pulse on reaching target
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned FRAME_US   = 20000,
    parameter int unsigned INIT_ANGLE = 90,
    parameter int unsigned DEF_STEP   = 2
) (
    input  logic                  iclk,
    input  logic                  reset_n,
    servo_ramp_ctrl_if.slave      cmd,
    output logic                  frame_tick,
    output logic [8*NUM_CH-1:0]   angle_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
);

    localparam logic [31:0] FrameCnt = frame_cnt(CLK_HZ, FRAME_US);

    logic [31:0]       cnt_q, cnt_d;
    logic              xfer;
    logic [NUM_CH-1:0] load;

    assign frame_tick    = (cnt_q == FrameCnt - 32'd1);
    // Commands are held off during the update cycle so load and tick never collide.
    assign cmd.cmd_ready = ~frame_tick;
    assign xfer          = cmd.cmd_valid & ~frame_tick;

    always_comb begin
        cnt_d = frame_tick ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Out-of-range channel indices match nothing, so the command is dropped.
    always_comb begin
        load = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            load[k] = xfer && (32'(cmd.cmd_ch) == 32'(k));
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
        servo_ramp_chan #(
            .INIT_ANGLE (INIT_ANGLE),
            .DEF_STEP   (DEF_STEP)
        ) u_chan (
            .iclk      (iclk),
            .reset_n   (reset_n),
            .load      (load[g]),
            .cmd_angle (cmd.cmd_angle),
            .cmd_step  (cmd.cmd_step),
            .tick      (frame_tick),
            .angle     (angle_out[8*g +: 8]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

endmodule
